// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity codes and baud divider table for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DIV_W = 14;

  // Clocks per 16x sample tick at 50 MHz for each baud_select code
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'b000:  baud_div = 14'd10417;
      3'b001:  baud_div = 14'd2604;
      3'b010:  baud_div = 14'd651;
      3'b011:  baud_div = 14'd326;
      3'b100:  baud_div = 14'd163;
      3'b101:  baud_div = 14'd81;
      3'b110:  baud_div = 14'd54;
      default: baud_div = 14'd27;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - 16x sample tick generator, counter held at zero while disabled
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] DIV,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt == DIV - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with majority sampling and receive FIFO
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    baud_select,
  input  logic                          Rx_EN,
  input  logic                          RxD,
  input  logic                          Rx_RD,
  output logic [DATA_W-1:0]             Rx_DATA,
  output logic                          Rx_VALID,
  output logic                          Rx_PERROR,
  output logic                          Rx_FERROR,
  output logic                          Rx_OVERRUN,
  output logic                          Rx_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   Rx_LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  rx_state_e        state_q, state_d;
  logic             rx_s1, rx_s2;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [3:0]       bit_cnt;
  logic [1:0]       stop_cnt;
  logic [1:0]       samp;
  logic             maj;
  logic [DATA_W-1:0] shreg;
  logic             perr_q, ferr_q;
  logic             push_pend;
  logic             push, do_push, do_pop, full;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level_q;
  logic [EW-1:0]    head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RxD;
      rx_s2 <= rx_s1;
    end
  end

  uart_baud_gen u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (Rx_EN && (state_q != ST_IDLE)),
    .DIV    (div_q),
    .tick   (tick)
  );

  // samp holds ticks 7 and 8; the live line value supplies tick 9
  assign maj = (samp[1] & samp[0]) | (samp[1] & rx_s2) | (samp[0] & rx_s2);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE:   if (!rx_s2) state_d = ST_START;
      ST_START: begin
        if (tick && tick_cnt == 4'd9 && maj)  state_d = ST_IDLE;
        else if (tick && tick_cnt == 4'd15)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick && tick_cnt == 4'd15 && bit_cnt == 4'(DATA_W - 1))
          state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: if (tick && tick_cnt == 4'd15) state_d = ST_STOP;
      ST_STOP: begin
        if (push_pend) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (!Rx_EN) begin
      state_d = ST_IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      samp      <= '0;
      shreg     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      push_pend <= 1'b0;
    end else if (!Rx_EN || state_q == ST_IDLE) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      push_pend <= 1'b0;
      if (Rx_EN && state_d == ST_START) begin
        div_q  <= baud_div(baud_select);
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
      if (tick_cnt == 4'd7 || tick_cnt == 4'd8) samp <= {samp[0], rx_s2};
      if (tick_cnt == 4'd9) begin
        case (state_q)
          ST_DATA:   shreg <= {maj, shreg[DATA_W-1:1]};
          ST_PARITY: perr_q <= (PARITY_MODE == PARITY_ODD) ? (maj == ^shreg) : (maj != ^shreg);
          ST_STOP: begin
            ferr_q <= ferr_q | ~maj;
            if (stop_cnt == 2'(STOP_BITS - 1)) push_pend <= 1'b1;
          end
          default: ;
        endcase
      end
      if (tick_cnt == 4'd15) begin
        if (state_q == ST_DATA) bit_cnt  <= bit_cnt + 1'b1;
        if (state_q == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = Rx_RD && (level_q != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {perr_q, ferr_q, shreg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      Rx_OVERRUN <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (!Rx_EN)                      Rx_OVERRUN <= 1'b0;
      else if (push && full && !do_pop) Rx_OVERRUN <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign Rx_VALID  = (level_q != '0);
  assign Rx_DATA   = Rx_VALID ? head[DATA_W-1:0] : '0;
  assign Rx_FERROR = Rx_VALID & head[DATA_W];
  assign Rx_PERROR = Rx_VALID & head[DATA_W+1];
  assign Rx_BUSY   = (state_q != ST_IDLE);
  assign Rx_LEVEL  = level_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed scoreboard bench for uart_rx_param at 115200 baud
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = 3'b111;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic       Rx_RD = 1'b0;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_OVERRUN, Rx_BUSY;
  logic [2:0] Rx_LEVEL;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  uart_rx_param dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .RxD         (RxD),
    .Rx_RD       (Rx_RD),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_OVERRUN  (Rx_OVERRUN),
    .Rx_BUSY     (Rx_BUSY),
    .Rx_LEVEL    (Rx_LEVEL)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      RxD = f[i];
      repeat (432) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 11);
    RxD = 1'b1;
    repeat (300) @(negedge clk);
  endtask

  task automatic drain();
    logic [9:0] e;
    int guard;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (!Rx_VALID && guard < 6000) begin
        @(negedge clk);
        guard++;
      end
      chk("pop_valid", 32'(Rx_VALID), 32'd1);
      e = exp_q.pop_front();
      chk("pop_data",   32'(Rx_DATA),   32'(e[7:0]));
      chk("pop_perror", 32'(Rx_PERROR), 32'(e[9]));
      chk("pop_ferror", 32'(Rx_FERROR), 32'(e[8]));
      Rx_RD = 1'b1;
      @(negedge clk);
      Rx_RD = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;

    repeat (3) @(negedge clk);
    chk("rst_valid",   32'(Rx_VALID),   32'd0);
    chk("rst_data",    32'(Rx_DATA),    32'd0);
    chk("rst_perror",  32'(Rx_PERROR),  32'd0);
    chk("rst_ferror",  32'(Rx_FERROR),  32'd0);
    chk("rst_overrun", 32'(Rx_OVERRUN), 32'd0);
    chk("rst_busy",    32'(Rx_BUSY),    32'd0);
    chk("rst_level",   32'(Rx_LEVEL),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // good frame; push lands in the middle of the stop bit
    send_bits(frame(8'hA5, 1'b0, 1'b1), 10);
    chk("a5_valid_before_stop", 32'(Rx_VALID), 32'd0);
    RxD = 1'b1;
    repeat (432) @(negedge clk);
    chk("a5_valid_after_stop", 32'(Rx_VALID), 32'd1);
    chk("a5_level", 32'(Rx_LEVEL), 32'd1);
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    drain();

    send_frame(frame(8'hA5, 1'b1, 1'b1));
    exp_q.push_back({1'b1, 1'b0, 8'hA5});
    drain();

    send_frame(frame(8'h3C, 1'b0, 1'b0));
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(frame(8'h55, 1'b0, 1'b1));
    exp_q.push_back({1'b0, 1'b0, 8'h55});
    drain();

    // short low pulse must be rejected as a glitch
    RxD = 1'b0;
    repeat (50) @(negedge clk);
    chk("glitch_busy_during", 32'(Rx_BUSY), 32'd1);
    repeat (50) @(negedge clk);
    RxD = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_busy_after", 32'(Rx_BUSY), 32'd0);
    chk("glitch_level", 32'(Rx_LEVEL), 32'd0);

    Rx_RD = 1'b1;
    @(negedge clk);
    Rx_RD = 1'b0;
    chk("empty_pop_level", 32'(Rx_LEVEL), 32'd0);
    chk("empty_pop_valid", 32'(Rx_VALID), 32'd0);

    for (int k = 1; k <= 5; k++) begin
      b = 8'(k);
      send_frame(frame(b, ^b, 1'b1));
      if (k <= 4) exp_q.push_back({1'b0, 1'b0, b});
    end
    chk("ovr_level", 32'(Rx_LEVEL), 32'd4);
    chk("ovr_flag", 32'(Rx_OVERRUN), 32'd1);
    drain();
    chk("ovr_drained_valid", 32'(Rx_VALID), 32'd0);
    chk("ovr_sticky", 32'(Rx_OVERRUN), 32'd1);
    Rx_EN = 1'b0;
    @(negedge clk);
    chk("ovr_clear_on_disable", 32'(Rx_OVERRUN), 32'd0);
    Rx_EN = 1'b1;
    @(negedge clk);

    // abort mid-data by disabling the receiver
    send_bits(frame(8'h77, ^8'h77, 1'b1), 4);
    chk("en_abort_busy_mid", 32'(Rx_BUSY), 32'd1);
    Rx_EN = 1'b0;
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    chk("en_abort_busy", 32'(Rx_BUSY), 32'd0);
    chk("en_abort_level", 32'(Rx_LEVEL), 32'd0);
    Rx_EN = 1'b1;
    repeat (432) @(negedge clk);
    send_frame(frame(8'h12, ^8'h12, 1'b1));
    exp_q.push_back({1'b0, 1'b0, 8'h12});
    chk("en_next_level", 32'(Rx_LEVEL), 32'd1);

    // abort mid-data by reset; the queued 0x12 must be flushed too
    send_bits(frame(8'h77, ^8'h77, 1'b1), 5);
    reset = 1'b1;
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_abort_busy", 32'(Rx_BUSY), 32'd0);
    chk("rst_abort_level", 32'(Rx_LEVEL), 32'd0);
    chk("rst_abort_valid", 32'(Rx_VALID), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (432) @(negedge clk);
    send_frame(frame(8'h12, ^8'h12, 1'b1));
    exp_q.push_back({1'b0, 1'b0, 8'h12});
    drain();
    chk("final_level", 32'(Rx_LEVEL), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_W, 8, data bits per frame; legal 5..9.
REQ-002 Parameter PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, 1, stop bits checked per frame; legal 1 or 2.
REQ-004 Parameter FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
REQ-005 clk  input  1  single system clock, 50 MHz; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 baud_select  input  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
REQ-008 Rx_EN  input  1  receiver enable.
REQ-009 RxD  input  1  asynchronous serial line, idle high.
REQ-010 Rx_RD  input  1  pop request for the FIFO head.
REQ-011 Rx_DATA  output  DATA_W  FIFO head data, first-word-fall-through.
REQ-012 Rx_VALID  output  1  FIFO non-empty.
REQ-013 Rx_PERROR  output  1  parity error flag of the head entry.
REQ-014 Rx_FERROR  output  1  framing error flag of the head entry.
REQ-015 Rx_OVERRUN  output  1  sticky: a frame was dropped because the FIFO was full.
REQ-016 Rx_BUSY  output  1  FSM not in IDLE.
REQ-017 Rx_LEVEL  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-018 RxD SHALL pass through a 2-flop synchroniser; both flops reset to 1.
REQ-019 The 16x sample tick SHALL be one clk pulse every DIV clocks, with DIV = 10417, 2604, 651, 326, 163, 81, 54, 27 for codes 000..111.
REQ-020 DIV SHALL be latched on the IDLE->START transition; baud_select changes mid-frame have no effect until the next frame.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE->START SHALL occur on the first clock on which synchronised RxD is 0 and Rx_EN=1. The tick counter SHALL be cleared on this transition.
REQ-023 Each bit value SHALL be the majority of sample ticks 7, 8 and 9 of that bit's 16-tick window.
REQ-024 START SHALL go to IDLE without a push if the start-bit majority is 1 (glitch rejection). Otherwise it goes to DATA.
REQ-025 DATA SHALL shift in DATA_W bits LSB first, then go to PARITY, or to STOP if PARITY_MODE=0.
REQ-026 PERROR SHALL be set when the received parity bit differs from the XOR of the data (even mode) or its complement (odd mode). It SHALL be 0 when PARITY_MODE=0.
REQ-027 FERROR SHALL be set if any checked stop bit's majority is 0.
REQ-028 After tick 9 of the last stop bit, the FSM SHALL push {PERROR, FERROR, data} on the next clock and return to IDLE. Rx_VALID SHALL rise one clock after the push.
REQ-029 Rx_RD with Rx_VALID=1 SHALL pop one entry per clock. Rx_RD with Rx_VALID=0 SHALL be ignored.
REQ-030 Push with the FIFO full and no pop SHALL drop the frame and set Rx_OVERRUN. Simultaneous push and pop when full SHALL both succeed with no overrun.
REQ-031 Rx_OVERRUN SHALL clear only on reset or when Rx_EN=0.
REQ-032 Rx_EN=0 SHALL force IDLE synchronously, discard any partial frame and hold the tick counter at 0. FIFO contents SHALL be retained and remain poppable.
REQ-033 Pointer arithmetic SHALL wrap modulo FIFO_DEPTH. Rx_LEVEL SHALL range from 0 to FIFO_DEPTH inclusive.

Reset
REQ-034 Reset SHALL set FSM=IDLE, all counters and pointers to 0, Rx_DATA=0, and Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_OVERRUN, Rx_BUSY and Rx_LEVEL to 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no push, and SHALL empty the FIFO.

Structure
REQ-036 Package uart_pkg SHALL hold the FSM state enum, the PARITY_MODE constants and the baud_select-to-DIV table function.
REQ-037 Tick generation SHALL live in sub-module uart_baud_gen (inputs: clk, reset, enable, DIV; output: tick). The FIFO is inline.

Verification (50 MHz, baud_select=111, bit = 432 clk, defaults unless stated)
REQ-038 Frame 0xA5, parity 0, stop 1 -> Rx_VALID=1 one clock after the push, Rx_DATA=0xA5, Rx_PERROR=0, Rx_FERROR=0, Rx_LEVEL=1.
REQ-039 Frame 0xA5, parity 1 -> Rx_DATA=0xA5, Rx_PERROR=1, Rx_FERROR=0.
REQ-040 Frame 0x3C, stop bit 0 -> Rx_FERROR=1; a following good frame 0x55 is received correctly.
REQ-041 RxD low for 100 clk, then high -> no push, Rx_BUSY returns to 0, Rx_LEVEL=0.
REQ-042 Five frames 0x01..0x05 with no Rx_RD -> Rx_LEVEL=4, Rx_OVERRUN=1; pops return 0x01..0x04 in order, then Rx_VALID=0.
REQ-043 Rx_EN=0 or reset asserted mid-DATA of frame 0x77 -> no push, FSM in IDLE; the next full frame 0x12 is received correctly.
